// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: codeword geometry, per-lane status and a lane popcount.
// Codeword layout: bit 0 is overall parity; bits 1..N form an extended Hamming
// code with check bits at power-of-two positions and payload bits elsewhere, in order.
package ecc_pkg;

    typedef enum logic [1:0] {
        NoErr  = 2'd0,
        Single = 2'd1,
        Double = 2'd2
    } lane_status_e;

    // Widest lane vector the popcount helper accepts.
    localparam int MaxLanes = 64;

    // Number of Hamming check bits r: the smallest r with 2^r >= data_width + r + 1.
    function automatic int get_par_bits(input int data_width);
        int r;
        r = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < data_width + r + 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Full codeword width: payload + Hamming check bits + overall parity bit.
    function automatic int get_cw_width(input int data_width);
        return data_width + get_par_bits(data_width) + 1;
    endfunction

    // Number of set bits in a lane flag vector (zero-extended to MaxLanes).
    function automatic logic [7:0] popcount(input logic [MaxLanes-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MaxLanes; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ecc_decode.sv
// Combinational SECDED decode of one codeword: corrects single errors,
// flags double (uncorrectable) errors.
module ecc_decode
    import ecc_pkg::*;
#(
    parameter  int DataWidth = 32,
    localparam int CwWidth   = get_cw_width(DataWidth)
) (
    input  logic [CwWidth-1:0]   cw_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 single_err_o,
    output logic                 double_err_o
);

    localparam int ParBits = get_par_bits(DataWidth);
    localparam int LastPos = CwWidth - 1;

    logic [ParBits-1:0] syndrome;
    logic               overall;
    logic               flip;
    lane_status_e       status;
    int                 idx;

    assign overall = ^cw_i;

    // Hamming syndrome: bit j is the parity of every position whose index has bit j set.
    always_comb begin
        syndrome = '0;
        for (int pos = 1; pos <= LastPos; pos++) begin
            for (int j = 0; j < ParBits; j++) begin
                if (pos[j]) begin
                    syndrome[j] = syndrome[j] ^ cw_i[pos];
                end
            end
        end
    end

    // Classify: odd overall parity with an in-range syndrome is one flipped bit
    // (syndrome 0 means the overall parity bit itself); even parity with a
    // non-zero syndrome, or an out-of-range syndrome, is uncorrectable.
    always_comb begin
        status = NoErr;
        if (overall) begin
            if (int'(syndrome) <= LastPos) begin
                status = Single;
            end else begin
                status = Double;
            end
        end else if (syndrome != '0) begin
            status = Double;
        end
    end

    assign flip         = (status == Single);
    assign single_err_o = (status == Single);
    assign double_err_o = (status == Double);

    // Gather payload bits from non-power-of-two positions, flipping the one the syndrome names.
    always_comb begin
        data_o = '0;
        idx    = 0;
        for (int pos = 3; pos <= LastPos; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_o[idx] = cw_i[pos] ^ (flip && (int'(syndrome) == pos));
                idx = idx + 1;
            end
        end
    end

endmodule

// File: rtl/ecc_err_counter.sv
// Saturating event counter with a variable per-cycle increment; clear wins over increment.
module ecc_err_counter #(
    parameter int CntWidth = 16,
    parameter int IncWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [IncWidth-1:0] inc_i,
    output logic [CntWidth-1:0] cnt_o
);

    // One bit wider than the wider operand so the sum can never wrap before the compare.
    localparam int SumWidth = ((IncWidth > CntWidth) ? IncWidth : CntWidth) + 1;
    localparam logic [SumWidth-1:0] MaxCnt = SumWidth'({CntWidth{1'b1}});

    logic [CntWidth-1:0] cnt_q;
    logic [SumWidth-1:0] sum;

    // Widened sum used for the saturation test.
    always_comb sum = SumWidth'(cnt_q) + SumWidth'(inc_i);

    // Counter register: clear has priority, then saturating add when enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (sum > MaxCnt) begin
                cnt_q <= '1;
            end else begin
                cnt_q <= sum[CntWidth-1:0];
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_stream_decode.sv
// Multi-lane SECDED checker on a valid/ready stream with one output register stage,
// per-class saturating error counters, a sticky uncorrectable flag and optional drop.
//
// valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// once valid is high it stays high with unchanged data until that transfer.
module ecc_stream_decode
    import ecc_pkg::*;
#(
    parameter  int DataWidth    = 32,
    parameter  int NumLanes     = 4,
    parameter  int CntWidth     = 16,
    parameter  int DropOnDouble = 0,
    localparam int CwWidth      = get_cw_width(DataWidth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [NumLanes*CwWidth-1:0]   cw_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NumLanes*DataWidth-1:0] data_o,
    output logic [NumLanes-1:0]           single_err_o,
    output logic [NumLanes-1:0]           double_err_o,
    output logic [CntWidth-1:0]           single_cnt_o,
    output logic [CntWidth-1:0]           double_cnt_o,
    input  logic                          cnt_clear_i,
    output logic                          err_sticky_o,
    input  logic                          err_clear_i
);

    localparam int IncWidth = $clog2(NumLanes + 1);

    logic [NumLanes*DataWidth-1:0] dec_data;
    logic [NumLanes-1:0]           dec_single;
    logic [NumLanes-1:0]           dec_double;
    logic [NumLanes-1:0]           hs_single;
    logic [NumLanes-1:0]           hs_double;
    logic [IncWidth-1:0]           single_inc;
    logic [IncWidth-1:0]           double_inc;
    logic                          in_hs;
    logic                          any_double;
    logic                          load;

    logic                          valid_q;
    logic [NumLanes*DataWidth-1:0] data_q;
    logic [NumLanes-1:0]           single_q;
    logic [NumLanes-1:0]           double_q;
    logic                          sticky_q;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        ecc_decode #(
            .DataWidth(DataWidth)
        ) u_dec (
            .cw_i        (cw_i[k*CwWidth +: CwWidth]),
            .data_o      (dec_data[k*DataWidth +: DataWidth]),
            .single_err_o(dec_single[k]),
            .double_err_o(dec_double[k])
        );
    end

    // Ready depends only on the output register and downstream ready.
    assign ready_o = ~valid_q | ready_i;
    assign in_hs   = valid_i & ready_o;

    // Gate every flag with the handshake so idle (possibly X) codewords never reach state.
    assign hs_single  = dec_single & {NumLanes{in_hs}};
    assign hs_double  = dec_double & {NumLanes{in_hs}};
    assign any_double = |hs_double;
    assign load       = in_hs & ~((DropOnDouble != 0) & any_double);

    assign single_inc = IncWidth'(popcount(MaxLanes'(hs_single)));
    assign double_inc = IncWidth'(popcount(MaxLanes'(hs_double)));

    // Output stage: load an accepted beat, otherwise release valid after downstream takes it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            single_q <= '0;
            double_q <= '0;
        end else if (load) begin
            valid_q  <= 1'b1;
            data_q   <= dec_data;
            single_q <= dec_single;
            double_q <= dec_double;
        end else if (ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    // Sticky uncorrectable flag: a new double error beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sticky_q <= 1'b0;
        end else if (any_double) begin
            sticky_q <= 1'b1;
        end else if (err_clear_i) begin
            sticky_q <= 1'b0;
        end
    end

    ecc_err_counter #(
        .CntWidth(CntWidth),
        .IncWidth(IncWidth)
    ) u_single_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (in_hs),
        .clr_i (cnt_clear_i),
        .inc_i (single_inc),
        .cnt_o (single_cnt_o)
    );

    ecc_err_counter #(
        .CntWidth(CntWidth),
        .IncWidth(IncWidth)
    ) u_double_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (in_hs),
        .clr_i (cnt_clear_i),
        .inc_i (double_inc),
        .cnt_o (double_cnt_o)
    );

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign single_err_o = single_q;
    assign double_err_o = double_q;
    assign err_sticky_o = sticky_q;

endmodule
